// File: rtl/rate_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : rate_sequencer
//  Brief    : Run-control sequencer for a 4-bit display counter. Accepts
//             start/stop/step/clear/load commands, owns the down-counting
//             rate divider and emits single-cycle increment enables.
//  Revision : 1.0 - initial release
// ============================================================================
module rate_sequencer #(
   parameter int RATE_W = 11,
   parameter int RATE1  = 499,
   parameter int RATE2  = 999,
   parameter int RATE3  = 1999
) (
   input  logic       ClockIn,
   input  logic       Reset,
   input  logic [1:0] Speed,
   input  logic       Start,
   input  logic       Stop,
   input  logic       Step,
   input  logic       Clear,
   input  logic       Load,
   input  logic [3:0] LoadValue,
   output logic [3:0] CounterValue,
   output logic       Enable,
   output logic       Running,
   output logic       Wrap
);

   localparam logic [RATE_W-1:0] c_reload1  = RATE_W'(RATE1);
   localparam logic [RATE_W-1:0] c_reload2  = RATE_W'(RATE2);
   localparam logic [RATE_W-1:0] c_reload3  = RATE_W'(RATE3);
   localparam logic [RATE_W-1:0] c_rate_one = RATE_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_STEP  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [RATE_W-1:0] r_rate;
   logic [RATE_W-1:0] w_rate_nxt;
   logic [RATE_W-1:0] w_reload;
   logic              r_origin;      // 1: STEP entered from PAUSE, 0: from IDLE
   logic              w_origin_nxt;
   logic              w_enable;

   // Divider reload value for the currently selected speed
   always_comb begin
      w_reload = '0;
      case (Speed)
         2'b01:   w_reload = c_reload1;
         2'b10:   w_reload = c_reload2;
         2'b11:   w_reload = c_reload3;
         default: w_reload = '0;
      endcase
   end

   // Increment pulse; Clear and Stop always suppress it on their edge
   always_comb begin
      w_enable = ((r_state == ST_RUN) && (r_rate == '0)) || (r_state == ST_STEP);
      if (Clear || Stop) begin
         w_enable = 1'b0;
      end
   end

   assign Enable  = w_enable;
   assign Running = (r_state == ST_RUN);
   assign Wrap    = w_enable && (CounterValue == 4'd15) && !Load;

   // Next-state and divider update, command priority Clear > Stop > Start > Step
   always_comb begin
      w_state_nxt  = r_state;
      w_rate_nxt   = r_rate;
      w_origin_nxt = r_origin;
      if (Clear) begin
         w_state_nxt = ST_IDLE;
         w_rate_nxt  = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!Stop) begin
                  if (Start) begin
                     w_state_nxt = ST_RUN;
                     w_rate_nxt  = w_reload;
                  end else if (Step) begin
                     w_state_nxt  = ST_STEP;
                     w_origin_nxt = 1'b0;
                  end
               end
            end
            ST_RUN: begin
               if (Stop) begin
                  w_state_nxt = ST_PAUSE;
               end else if (r_rate == '0) begin
                  w_rate_nxt = w_reload;
               end else begin
                  w_rate_nxt = r_rate - c_rate_one;
               end
            end
            ST_PAUSE: begin
               // Divider is frozen; resuming continues the interrupted period
               if (!Stop) begin
                  if (Start) begin
                     w_state_nxt = ST_RUN;
                  end else if (Step) begin
                     w_state_nxt  = ST_STEP;
                     w_origin_nxt = 1'b1;
                  end
               end
            end
            ST_STEP: begin
               w_state_nxt = r_origin ? ST_PAUSE : ST_IDLE;
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // State, divider and origin registers
   always_ff @(posedge ClockIn or negedge Reset) begin
      if (!Reset) begin
         r_state  <= ST_IDLE;
         r_rate   <= '0;
         r_origin <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_rate   <= w_rate_nxt;
         r_origin <= w_origin_nxt;
      end
   end

   // Display counter: Clear beats Load, Load beats the increment
   always_ff @(posedge ClockIn or negedge Reset) begin
      if (!Reset) begin
         CounterValue <= 4'd0;
      end else if (Clear) begin
         CounterValue <= 4'd0;
      end else if (Load) begin
         CounterValue <= LoadValue;
      end else if (w_enable) begin
         CounterValue <= CounterValue + 4'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rate_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rate_sequencer
//  Brief    : Self-checking bench for rate_sequencer with a per-cycle
//             expectation queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rate_sequencer;

   logic       ClockIn;
   logic       Reset;
   logic [1:0] Speed;
   logic       Start;
   logic       Stop;
   logic       Step;
   logic       Clear;
   logic       Load;
   logic [3:0] LoadValue;
   logic [3:0] CounterValue;
   logic       Enable;
   logic       Running;
   logic       Wrap;

   logic [6:0] obs;
   logic [6:0] sb[$];
   int         n_cmp;
   int         n_err;

   rate_sequencer #(
      .RATE_W (11),
      .RATE1  (3),
      .RATE2  (7),
      .RATE3  (15)
   ) dut (
      .ClockIn      (ClockIn),
      .Reset        (Reset),
      .Speed        (Speed),
      .Start        (Start),
      .Stop         (Stop),
      .Step         (Step),
      .Clear        (Clear),
      .Load         (Load),
      .LoadValue    (LoadValue),
      .CounterValue (CounterValue),
      .Enable       (Enable),
      .Running      (Running),
      .Wrap         (Wrap)
   );

   assign obs = {CounterValue, Enable, Running, Wrap};

   initial ClockIn = 1'b0;
   always #5 ClockIn = ~ClockIn;

   // Command word: {Speed, Start, Stop, Step, Clear, Load, LoadValue}
   function automatic logic [10:0] cmd(input logic [1:0] sp, input logic st, input logic sto,
                                       input logic stp, input logic clr, input logic ld,
                                       input logic [3:0] lv);
      return {sp, st, sto, stp, clr, ld, lv};
   endfunction

   // Expected observation: {CounterValue, Enable, Running, Wrap}
   function automatic logic [6:0] ex(input logic [3:0] cnt, input logic en, input logic run,
                                     input logic wr);
      return {cnt, en, run, wr};
   endfunction

   // Drive one cycle of commands just after the edge and queue its expectation
   task automatic apply(input logic [10:0] c, input logic [6:0] x);
      @(posedge ClockIn);
      #1;
      {Speed, Start, Stop, Step, Clear, Load, LoadValue} = c;
      sb.push_back(x);
   endtask

   task automatic test_reset();
      logic [6:0] want;
      for (int i = 0; i < 8; i++) begin
         apply(cmd(2'b00, 0, 0, 0, 0, 0, 4'd0), ex(4'd0, 0, 0, 0));
         if (i == 3) Reset = 1'b1;
         @(negedge ClockIn);
         want = sb.pop_front();
         n_cmp++;
         if (obs !== want) begin
            n_err++;
            $display("FAIL reset[%0d]: got cnt=%0d en=%b run=%b wrap=%b want cnt=%0d en=%b run=%b wrap=%b",
                     i, obs[6:3], obs[2], obs[1], obs[0], want[6:3], want[2], want[1], want[0]);
         end
      end
   endtask

   task automatic test_run();
      logic [10:0] cq[$];
      logic [6:0]  xq[$];
      logic [6:0]  want;
      cq.push_back(cmd(2'b01, 1, 0, 0, 0, 0, 4'd0)); xq.push_back(ex(4'd0, 0, 0, 0));
      for (int k = 1; k <= 12; k++) begin
         cq.push_back(cmd(2'b01, 0, 0, 0, 0, 0, 4'd0));
         xq.push_back(ex(4'((k - 1) / 4), (k % 4) == 0, 1'b1, 1'b0));
      end
      cq.push_back(cmd(2'b01, 0, 0, 0, 1, 0, 4'd0)); xq.push_back(ex(4'd3, 0, 1, 0));
      cq.push_back(cmd(2'b01, 0, 0, 0, 0, 0, 4'd0)); xq.push_back(ex(4'd0, 0, 0, 0));
      for (int i = 0; i < cq.size(); i++) begin
         apply(cq[i], xq[i]);
         @(negedge ClockIn);
         want = sb.pop_front();
         n_cmp++;
         if (obs !== want) begin
            n_err++;
            $display("FAIL run[%0d]: got cnt=%0d en=%b run=%b wrap=%b want cnt=%0d en=%b run=%b wrap=%b",
                     i, obs[6:3], obs[2], obs[1], obs[0], want[6:3], want[2], want[1], want[0]);
         end
      end
   endtask

   task automatic test_wrap();
      logic [10:0] cq[$];
      logic [6:0]  xq[$];
      logic [6:0]  want;
      cq.push_back(cmd(2'b00, 0, 0, 0, 0, 1, 4'd14)); xq.push_back(ex(4'd0,  0, 0, 0));
      cq.push_back(cmd(2'b00, 1, 0, 0, 0, 0, 4'd0));  xq.push_back(ex(4'd14, 0, 0, 0));
      cq.push_back(cmd(2'b00, 0, 0, 0, 0, 0, 4'd0));  xq.push_back(ex(4'd14, 1, 1, 0));
      cq.push_back(cmd(2'b00, 0, 0, 0, 0, 0, 4'd0));  xq.push_back(ex(4'd15, 1, 1, 1));
      cq.push_back(cmd(2'b00, 0, 0, 0, 0, 0, 4'd0));  xq.push_back(ex(4'd0,  1, 1, 0));
      cq.push_back(cmd(2'b00, 0, 0, 0, 0, 0, 4'd0));  xq.push_back(ex(4'd1,  1, 1, 0));
      cq.push_back(cmd(2'b00, 0, 0, 0, 1, 0, 4'd0));  xq.push_back(ex(4'd2,  0, 1, 0));
      cq.push_back(cmd(2'b00, 0, 0, 0, 0, 0, 4'd0));  xq.push_back(ex(4'd0,  0, 0, 0));
      for (int i = 0; i < cq.size(); i++) begin
         apply(cq[i], xq[i]);
         @(negedge ClockIn);
         want = sb.pop_front();
         n_cmp++;
         if (obs !== want) begin
            n_err++;
            $display("FAIL wrap[%0d]: got cnt=%0d en=%b run=%b wrap=%b want cnt=%0d en=%b run=%b wrap=%b",
                     i, obs[6:3], obs[2], obs[1], obs[0], want[6:3], want[2], want[1], want[0]);
         end
      end
   endtask

   task automatic test_pause();
      logic [10:0] cq[$];
      logic [6:0]  xq[$];
      logic [6:0]  want;
      cq.push_back(cmd(2'b10, 1, 0, 0, 0, 0, 4'd0)); xq.push_back(ex(4'd0, 0, 0, 0));
      for (int k = 0; k < 2; k++) begin
         cq.push_back(cmd(2'b10, 0, 0, 0, 0, 0, 4'd0)); xq.push_back(ex(4'd0, 0, 1, 0));
      end
      cq.push_back(cmd(2'b10, 0, 1, 0, 0, 0, 4'd0)); xq.push_back(ex(4'd0, 0, 1, 0));
      for (int k = 0; k < 10; k++) begin
         cq.push_back(cmd(2'b10, 0, 0, 0, 0, 0, 4'd0)); xq.push_back(ex(4'd0, 0, 0, 0));
      end
      cq.push_back(cmd(2'b10, 1, 0, 0, 0, 0, 4'd0)); xq.push_back(ex(4'd0, 0, 0, 0));
      for (int k = 0; k < 5; k++) begin
         cq.push_back(cmd(2'b10, 0, 0, 0, 0, 0, 4'd0)); xq.push_back(ex(4'd0, 0, 1, 0));
      end
      cq.push_back(cmd(2'b10, 0, 0, 0, 0, 0, 4'd0)); xq.push_back(ex(4'd0, 1, 1, 0));
      cq.push_back(cmd(2'b10, 0, 1, 0, 0, 0, 4'd0)); xq.push_back(ex(4'd1, 0, 1, 0));
      cq.push_back(cmd(2'b10, 0, 0, 0, 0, 0, 4'd0)); xq.push_back(ex(4'd1, 0, 0, 0));
      cq.push_back(cmd(2'b10, 0, 0, 1, 0, 0, 4'd0)); xq.push_back(ex(4'd1, 0, 0, 0));
      cq.push_back(cmd(2'b10, 0, 0, 0, 0, 0, 4'd0)); xq.push_back(ex(4'd1, 1, 0, 0));
      cq.push_back(cmd(2'b10, 0, 0, 0, 0, 0, 4'd0)); xq.push_back(ex(4'd2, 0, 0, 0));
      cq.push_back(cmd(2'b10, 1, 0, 0, 0, 0, 4'd0)); xq.push_back(ex(4'd2, 0, 0, 0));
      cq.push_back(cmd(2'b10, 0, 0, 0, 0, 0, 4'd0)); xq.push_back(ex(4'd2, 0, 1, 0));
      cq.push_back(cmd(2'b10, 0, 0, 0, 1, 0, 4'd0)); xq.push_back(ex(4'd2, 0, 1, 0));
      cq.push_back(cmd(2'b10, 0, 0, 0, 0, 0, 4'd0)); xq.push_back(ex(4'd0, 0, 0, 0));
      for (int i = 0; i < cq.size(); i++) begin
         apply(cq[i], xq[i]);
         @(negedge ClockIn);
         want = sb.pop_front();
         n_cmp++;
         if (obs !== want) begin
            n_err++;
            $display("FAIL pause[%0d]: got cnt=%0d en=%b run=%b wrap=%b want cnt=%0d en=%b run=%b wrap=%b",
                     i, obs[6:3], obs[2], obs[1], obs[0], want[6:3], want[2], want[1], want[0]);
         end
      end
   endtask

   task automatic test_step();
      logic [10:0] cq[$];
      logic [6:0]  xq[$];
      logic [6:0]  want;
      cq.push_back(cmd(2'b01, 0, 0, 1, 0, 0, 4'd0)); xq.push_back(ex(4'd0, 0, 0, 0));
      cq.push_back(cmd(2'b01, 0, 0, 0, 0, 0, 4'd0)); xq.push_back(ex(4'd0, 1, 0, 0));
      cq.push_back(cmd(2'b01, 0, 0, 0, 0, 0, 4'd0)); xq.push_back(ex(4'd1, 0, 0, 0));
      cq.push_back(cmd(2'b01, 0, 0, 0, 0, 0, 4'd0)); xq.push_back(ex(4'd1, 0, 0, 0));
      cq.push_back(cmd(2'b01, 1, 0, 0, 0, 0, 4'd0)); xq.push_back(ex(4'd1, 0, 0, 0));
      cq.push_back(cmd(2'b01, 0, 0, 1, 0, 0, 4'd0)); xq.push_back(ex(4'd1, 0, 1, 0));
      cq.push_back(cmd(2'b01, 0, 0, 0, 0, 0, 4'd0)); xq.push_back(ex(4'd1, 0, 1, 0));
      cq.push_back(cmd(2'b01, 0, 0, 0, 0, 0, 4'd0)); xq.push_back(ex(4'd1, 0, 1, 0));
      cq.push_back(cmd(2'b01, 0, 0, 0, 0, 0, 4'd0)); xq.push_back(ex(4'd1, 1, 1, 0));
      cq.push_back(cmd(2'b01, 0, 0, 0, 1, 0, 4'd0)); xq.push_back(ex(4'd2, 0, 1, 0));
      cq.push_back(cmd(2'b01, 0, 0, 0, 0, 0, 4'd0)); xq.push_back(ex(4'd0, 0, 0, 0));
      for (int i = 0; i < cq.size(); i++) begin
         apply(cq[i], xq[i]);
         @(negedge ClockIn);
         want = sb.pop_front();
         n_cmp++;
         if (obs !== want) begin
            n_err++;
            $display("FAIL step[%0d]: got cnt=%0d en=%b run=%b wrap=%b want cnt=%0d en=%b run=%b wrap=%b",
                     i, obs[6:3], obs[2], obs[1], obs[0], want[6:3], want[2], want[1], want[0]);
         end
      end
   endtask

   task automatic test_stop_at_zero();
      logic [10:0] cq[$];
      logic [6:0]  xq[$];
      logic [6:0]  want;
      cq.push_back(cmd(2'b00, 1, 0, 0, 0, 0, 4'd0)); xq.push_back(ex(4'd0, 0, 0, 0));
      cq.push_back(cmd(2'b00, 0, 1, 0, 0, 0, 4'd0)); xq.push_back(ex(4'd0, 0, 1, 0));
      cq.push_back(cmd(2'b00, 0, 0, 0, 0, 0, 4'd0)); xq.push_back(ex(4'd0, 0, 0, 0));
      cq.push_back(cmd(2'b00, 0, 0, 0, 1, 0, 4'd0)); xq.push_back(ex(4'd0, 0, 0, 0));
      cq.push_back(cmd(2'b00, 0, 0, 0, 0, 0, 4'd0)); xq.push_back(ex(4'd0, 0, 0, 0));
      for (int i = 0; i < cq.size(); i++) begin
         apply(cq[i], xq[i]);
         @(negedge ClockIn);
         want = sb.pop_front();
         n_cmp++;
         if (obs !== want) begin
            n_err++;
            $display("FAIL stopzero[%0d]: got cnt=%0d en=%b run=%b wrap=%b want cnt=%0d en=%b run=%b wrap=%b",
                     i, obs[6:3], obs[2], obs[1], obs[0], want[6:3], want[2], want[1], want[0]);
         end
      end
   endtask

   task automatic test_load_clear();
      logic [10:0] cq[$];
      logic [6:0]  xq[$];
      logic [6:0]  want;
      cq.push_back(cmd(2'b00, 1, 0, 0, 0, 0, 4'd0));  xq.push_back(ex(4'd0,  0, 0, 0));
      cq.push_back(cmd(2'b00, 0, 0, 0, 0, 1, 4'd15)); xq.push_back(ex(4'd0,  1, 1, 0));
      cq.push_back(cmd(2'b00, 0, 0, 0, 0, 1, 4'd9));  xq.push_back(ex(4'd15, 1, 1, 0));
      cq.push_back(cmd(2'b00, 0, 0, 0, 0, 0, 4'd0));  xq.push_back(ex(4'd9,  1, 1, 0));
      cq.push_back(cmd(2'b00, 0, 0, 0, 0, 0, 4'd0));  xq.push_back(ex(4'd10, 1, 1, 0));
      cq.push_back(cmd(2'b00, 1, 0, 0, 1, 0, 4'd0));  xq.push_back(ex(4'd11, 0, 1, 0));
      cq.push_back(cmd(2'b00, 0, 0, 0, 0, 0, 4'd0));  xq.push_back(ex(4'd0,  0, 0, 0));
      cq.push_back(cmd(2'b00, 0, 0, 0, 0, 0, 4'd0));  xq.push_back(ex(4'd0,  0, 0, 0));
      for (int i = 0; i < cq.size(); i++) begin
         apply(cq[i], xq[i]);
         @(negedge ClockIn);
         want = sb.pop_front();
         n_cmp++;
         if (obs !== want) begin
            n_err++;
            $display("FAIL loadclear[%0d]: got cnt=%0d en=%b run=%b wrap=%b want cnt=%0d en=%b run=%b wrap=%b",
                     i, obs[6:3], obs[2], obs[1], obs[0], want[6:3], want[2], want[1], want[0]);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [6:0] want;
      for (int i = 0; i < 6; i++) begin
         case (i)
            0:       apply(cmd(2'b00, 1, 0, 0, 0, 0, 4'd0), ex(4'd0, 0, 0, 0));
            1:       apply(cmd(2'b00, 0, 0, 0, 0, 0, 4'd0), ex(4'd0, 1, 1, 0));
            2:       apply(cmd(2'b00, 0, 0, 0, 0, 0, 4'd0), ex(4'd1, 1, 1, 0));
            default: apply(cmd(2'b00, 0, 0, 0, 0, 0, 4'd0), ex(4'd0, 0, 0, 0));
         endcase
         if (i == 3) Reset = 1'b0;
         if (i == 4) Reset = 1'b1;
         @(negedge ClockIn);
         want = sb.pop_front();
         n_cmp++;
         if (obs !== want) begin
            n_err++;
            $display("FAIL asyncreset[%0d]: got cnt=%0d en=%b run=%b wrap=%b want cnt=%0d en=%b run=%b wrap=%b",
                     i, obs[6:3], obs[2], obs[1], obs[0], want[6:3], want[2], want[1], want[0]);
         end
      end
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      Reset     = 1'b0;
      Speed     = 2'b00;
      Start     = 1'b0;
      Stop      = 1'b0;
      Step      = 1'b0;
      Clear     = 1'b0;
      Load      = 1'b0;
      LoadValue = 4'd0;
      test_reset();
      test_run();
      test_wrap();
      test_pause();
      test_step();
      test_stop_at_zero();
      test_load_clear();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got time limit reached, want bench completion");
      $fatal(1, "bench time limit expired");
   end

endmodule
`default_nettype wire
